// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART-side signals of the UART transmit arbiter.
// The arbiter uses the master modport; the producers/UART side uses slave.
interface uart_tx_arbiter_if #(
  parameter int unsigned NumReq = 4
);
  logic [8*NumReq-1:0] req_data;
  logic [NumReq-1:0]   req_valid;
  logic [NumReq-1:0]   req_last;
  logic [NumReq-1:0]   req_ready;
  logic [7:0]          data_in;
  logic                data_in_valid;
  logic                data_in_ready;
  logic [NumReq-1:0]   grant;
  logic                busy;
  logic                timeout;

  modport master (
    input  req_data, req_valid, req_last, data_in_ready,
    output req_ready, data_in, data_in_valid, grant, busy, timeout
  );

  modport slave (
    output req_data, req_valid, req_last, data_in_ready,
    input  req_ready, data_in, data_in_valid, grant, busy, timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one UART transmit channel.
// Owner keeps the grant until a last byte or an owner-stall timeout.
module uart_tx_arbiter #(
  parameter int unsigned NumReq        = 4,
  parameter int unsigned TimeoutCycles = 1024
) (
  input logic               clk,
  input logic               rst,
  uart_tx_arbiter_if.master bus
);

  localparam int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned CntW   = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam int unsigned CntMax = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e            state, state_d;
  logic [IdxW-1:0]   owner, ptr, pick_idx, owner_nxt;
  logic              pick_found;
  logic [CntW-1:0]   stall_cnt;
  logic [7:0]        out_data;
  logic              out_valid, out_valid_d;
  logic [NumReq-1:0] grant_q;
  logic              busy_q, timeout_q;
  logic              own_valid, own_last;
  logic [7:0]        own_data;
  logic [NumReq-1:0] ready_c;
  logic              accept, stall_hit;

  assign own_valid = bus.req_valid[owner];
  assign own_last  = bus.req_last[owner];
  assign own_data  = bus.req_data[{owner, 3'b000} +: 8];
  assign owner_nxt = (owner == LastIdx) ? '0 : owner + IdxW'(1);

  // First requesting index scanning ptr, ptr+1, ... with wrap
  always_comb begin
    pick_idx   = ptr;
    pick_found = 1'b0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      int unsigned idx;
      idx = (32'(ptr) + k) % NumReq;
      if (!pick_found && bus.req_valid[IdxW'(idx)]) begin
        pick_idx   = IdxW'(idx);
        pick_found = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (pick_found) state_d = LOCKED;
      LOCKED:  if ((accept && own_last) || stall_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Owner handshake and stall detection; ready only reaches the owner
  always_comb begin
    ready_c   = '0;
    accept    = 1'b0;
    stall_hit = 1'b0;
    if (state == LOCKED) begin
      ready_c[owner] = !out_valid || bus.data_in_ready;
      accept         = own_valid && ready_c[owner];
      stall_hit      = (TimeoutCycles != 0) && !own_valid && (stall_cnt == CntW'(CntMax));
    end
  end

  // A load in the same cycle as a drain replaces the byte without a bubble
  assign out_valid_d = accept || (out_valid && !bus.data_in_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= '0;
      ptr       <= '0;
      stall_cnt <= '0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      out_valid <= out_valid_d;
      if (accept) out_data <= own_data;
      timeout_q <= stall_hit;
      busy_q    <= (state_d == LOCKED) || out_valid_d;
      if (state == IDLE) begin
        stall_cnt <= '0;
        if (pick_found) begin
          owner   <= pick_idx;
          grant_q <= NumReq'(1) << pick_idx;
        end
      end else begin
        if (own_valid)                              stall_cnt <= '0;
        else if ((TimeoutCycles != 0) && !stall_hit) stall_cnt <= stall_cnt + CntW'(1);
        if (state_d == IDLE) begin
          grant_q <= '0;
          ptr     <= owner_nxt;
        end
      end
    end
  end

  assign bus.req_ready     = ready_c;
  assign bus.data_in       = out_data;
  assign bus.data_in_valid = out_valid;
  assign bus.grant         = grant_q;
  assign bus.busy          = busy_q;
  assign bus.timeout       = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter: a message-level
// round-robin model predicts grants, byte order and timeout pulses.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int T = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NumReq(N)) bus ();
  uart_tx_arbiter #(.NumReq(N), .TimeoutCycles(T)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Requester-side message state
  logic [7:0] msg [N][8];
  int  len [N];
  int  pos [N];
  int  gap [N];
  int  cool [N];
  int  left [N];
  bit  active [N];
  bit  no_last [N];

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  int m_ptr = 0;
  int sc = 0;
  int to_seen = 0;
  int rdy_mode = 0;
  bit gaps_on = 0;
  bit rdy_cur = 0;
  logic [N-1:0] prev_g = '0;
  logic [N-1:0] prev_v = '0;
  logic [N-1:0] g = '0;
  logic dv = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      automatic int idx = (p + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic bit all_idle();
    bit any = 0;
    for (int i = 0; i < N; i++) if (active[i]) any = 1;
    return !any && (exp_q.size() == 0) && (g == '0) && !dv;
  endfunction

  task automatic start_msg(input int i, input int n, input logic [63:0] bytes, input bit nl);
    for (int k = 0; k < n; k++) msg[i][k] = bytes[8*k +: 8];
    len[i] = n; pos[i] = 0; gap[i] = 0; no_last[i] = nl; active[i] = 1;
  endtask

  // One clock cycle: check registered outputs against the model, then drive
  task automatic step();
    logic [N-1:0] v, l, hs, exp_g;
    logic [8*N-1:0] d;
    int p;
    @(negedge clk);
    g  = bus.grant;
    dv = bus.data_in_valid;
    if (!rst) begin
      if (prev_g == '0) begin
        exp_g = '0;
        p = pick(prev_v, m_ptr);
        if (p >= 0) begin
          exp_g[p] = 1'b1;
          for (int k = 0; k < len[p]; k++) exp_q.push_back(msg[p][k]);
        end
        chk("grant", 32'(g), 32'(exp_g));
      end else if (g == '0) begin
        m_ptr = (idx_of(prev_g) + 1) % N;
      end else begin
        chk("grant_hold", 32'(g), 32'(prev_g));
      end
      chk("timeout", 32'(bus.timeout), 32'((prev_g != '0) && (sc == T)));
      if ((prev_g != '0) && (sc == T)) chk("timeout_release", 32'(g), 32'(0));
      if (bus.timeout) to_seen++;
      chk("busy", 32'(bus.busy), 32'((g != '0) || dv));
    end
    case (rdy_mode)
      1:       rdy_cur = 1'b1;
      2:       rdy_cur = 1'b0;
      default: rdy_cur = ($urandom_range(0, 3) != 0);
    endcase
    v = '0; l = '0; d = '0;
    for (int i = 0; i < N; i++) begin
      if (active[i] && gap[i] == 0) begin
        v[i] = 1'b1;
        d[8*i +: 8] = msg[i][pos[i]];
        l[i] = (pos[i] == len[i] - 1) && !no_last[i];
      end
    end
    bus.req_valid = v; bus.req_data = d; bus.req_last = l;
    bus.data_in_ready = rdy_cur;
    if (g != '0 && !rst) sc = v[idx_of(g)] ? 0 : sc + 1;
    else sc = 0;
    #1;
    if (!rst) begin
      chk("ready_other", 32'(bus.req_ready & ~g), 32'(0));
      if (g != '0) chk("ready_owner", 32'(|(bus.req_ready & g)), 32'(!dv || rdy_cur));
    end
    hs = v & bus.req_ready;
    for (int i = 0; i < N; i++) begin
      if (gap[i] > 0) gap[i]--;
      else if (hs[i]) begin
        pos[i]++;
        if (pos[i] == len[i]) begin
          active[i] = 0;
          cool[i] = $urandom_range(0, 6);
        end else if (gaps_on) gap[i] = $urandom_range(0, 3);
      end else if (!active[i] && cool[i] > 0) cool[i]--;
    end
    prev_g = rst ? '0 : g;
    prev_v = v;
  endtask

  task automatic wait_idle(input string name, input int max);
    for (int k = 0; k < max; k++) begin
      if (all_idle()) break;
      step();
    end
    chk(name, 32'(all_idle()), 32'(1));
  endtask

  // Output monitor: pops the scoreboard on every UART handshake
  initial begin
    bit hold_pend = 0;
    logic [7:0] hold_data = 8'h00;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        hold_pend = 0;
      end else begin
        if (hold_pend) begin
          chk("hold_valid", 32'(bus.data_in_valid), 32'(1));
          chk("hold_data", 32'(bus.data_in), 32'(hold_data));
        end
        if (bus.data_in_valid && bus.data_in_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_unexpected actual=%0h required=none", bus.data_in);
          end else begin
            chk("byte", 32'(bus.data_in), 32'(exp_q.pop_front()));
          end
        end
        hold_pend = bus.data_in_valid && !bus.data_in_ready;
        hold_data = bus.data_in;
      end
    end
  end

  initial begin
    int p0, t0;
    for (int i = 0; i < N; i++) begin
      len[i] = 1; pos[i] = 0; gap[i] = 0; cool[i] = 0; left[i] = 0;
      active[i] = 0; no_last[i] = 0;
    end
    rst = 1'b1;
    bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0; bus.data_in_ready = 1'b0;
    repeat (10) step();
    chk("rst_grant", 32'(bus.grant), 32'(0));
    chk("rst_valid", 32'(bus.data_in_valid), 32'(0));
    chk("rst_data", 32'(bus.data_in), 32'(0));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_timeout", 32'(bus.timeout), 32'(0));
    chk("rst_ready", 32'(bus.req_ready), 32'(0));
    rst = 1'b0;
    repeat (3) step();

    // Single message from requester 1
    rdy_mode = 1;
    start_msg(1, 3, 64'h21_69_48, 0);
    wait_idle("idle_msg1", 100);

    // Two simultaneous, then another pair
    rdy_mode = 0;
    start_msg(0, 2, 64'hA1_A0, 0);
    start_msg(2, 2, 64'hC1_C0, 0);
    wait_idle("idle_pair02", 200);
    start_msg(1, 2, 64'h11_10, 0);
    start_msg(3, 2, 64'h31_30, 0);
    wait_idle("idle_pair13", 200);

    // UART back-pressure with a byte pending
    rdy_mode = 1;
    start_msg(3, 4, 64'h44_43_42_41, 0);
    for (int k = 0; k < 20 && pos[3] < 1; k++) step();
    rdy_mode = 2;
    p0 = pos[3];
    repeat (20) step();
    chk("stall_no_accept", 32'(pos[3]), 32'(p0));
    rdy_mode = 1;
    step();
    chk("accept_on_release", 32'(pos[3]), 32'(p0 + 1));
    wait_idle("idle_backpressure", 100);

    // Owner stall timeout while another requester waits
    rdy_mode = 0;
    t0 = to_seen;
    start_msg(0, 1, 64'h55, 1);
    repeat (2) step();
    start_msg(1, 2, 64'h1B_1A, 0);
    wait_idle("idle_timeout", 200);
    chk("timeout_count", 32'(to_seen - t0), 32'(1));

    // Random traffic with valid gaps and random UART readiness
    gaps_on = 1;
    for (int i = 0; i < N; i++) left[i] = 6;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!active[i] && cool[i] == 0 && left[i] > 0 && $urandom_range(0, 3) == 0) begin
          start_msg(i, $urandom_range(1, 6), {$urandom, $urandom}, 0);
          left[i]--;
        end
      end
      step();
    end
    wait_idle("idle_random", 3000);

    // Reset in the middle of a message
    gaps_on = 0;
    rdy_mode = 1;
    start_msg(2, 5, 64'h00_00_00_E4_E3_E2_E1_E0, 0);
    start_msg(3, 2, 64'hF1_F0, 0);
    for (int k = 0; k < 20 && pos[2] < 2; k++) step();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_grant", 32'(bus.grant), 32'(0));
    chk("mid_rst_valid", 32'(bus.data_in_valid), 32'(0));
    chk("mid_rst_data", 32'(bus.data_in), 32'(0));
    chk("mid_rst_busy", 32'(bus.busy), 32'(0));
    chk("mid_rst_ready", 32'(bus.req_ready), 32'(0));
    exp_q.delete();
    pos[2] = 0; pos[3] = 0; gap[2] = 0; gap[3] = 0;
    m_ptr = 0; sc = 0;
    repeat (3) step();
    rst = 1'b0;
    wait_idle("idle_after_reset", 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
